// File: rtl/base_lane_pack.sv
// Streaming lane packer: concatenates left-justified partial beats into dense
// output beats, carrying leftover lanes in a residual register between beats.
module base_lane_pack #(
  parameter int unsigned width     = 8,
  parameter int unsigned ways      = 4,
  parameter int unsigned cnt_width = $clog2(ways + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [ways*width-1:0]  i_d,
  input  logic [cnt_width-1:0]   i_cnt,
  input  logic                   i_e,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [ways*width-1:0]  o_d,
  output logic [cnt_width-1:0]   o_cnt,
  output logic                   o_e
);

  localparam int unsigned dw = ways * width;
  localparam int unsigned lw = (ways > 1) ? $clog2(ways) : 1;
  localparam int unsigned sw = cnt_width + 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]           r_state;
  logic [dw-1:0]        r_hold;
  logic [cnt_width-1:0] r_hold_cnt;
  logic                 r_o_v;
  logic [dw-1:0]        r_o_d;
  logic [cnt_width-1:0] r_o_cnt;
  logic                 r_o_e;

  logic [0:0]           w_state_nxt;
  logic [dw-1:0]        w_hold_nxt;
  logic [cnt_width-1:0] w_hold_cnt_nxt;
  logic                 w_o_v_nxt;
  logic [dw-1:0]        w_o_d_nxt;
  logic [cnt_width-1:0] w_o_cnt_nxt;
  logic                 w_o_e_nxt;

  logic                 w_ld;
  logic                 w_ir;
  logic                 w_acc;
  logic [sw-1:0]        w_sum;
  logic [lw-1:0]        w_rot_amt;
  int unsigned          w_sh_l;
  int unsigned          w_sh_r;
  logic [dw-1:0]        w_rotl;
  logic [dw-1:0]        w_merge;
  logic [dw-1:0]        w_out;
  logic [dw-1:0]        w_flush;

  assign w_ld  = ~r_o_v | o_r;
  assign w_ir  = ~reset & (r_state == S_RUN) & w_ld;
  assign w_acc = i_v & w_ir;
  assign w_sum = sw'(r_hold_cnt) + sw'(i_cnt);

  // Input lane k lands at position (hold_cnt + k) mod ways after the rotate.
  always_comb begin
    w_rot_amt = lw'(cnt_width'(ways) - r_hold_cnt);
    w_sh_l    = 32'(w_rot_amt) * width;
    w_sh_r    = dw - w_sh_l;
    w_rotl    = (i_d << w_sh_l) | (i_d >> w_sh_r);
    w_merge   = '0;
    w_out     = '0;
    w_flush   = '0;
    for (int p = 0; p < int'(ways); p++) begin
      if (cnt_width'(p) < r_hold_cnt) begin
        w_merge[(int'(ways) - 1 - p) * int'(width) +: width] =
          r_hold[(int'(ways) - 1 - p) * int'(width) +: width];
        w_flush[(int'(ways) - 1 - p) * int'(width) +: width] =
          r_hold[(int'(ways) - 1 - p) * int'(width) +: width];
      end else begin
        w_merge[(int'(ways) - 1 - p) * int'(width) +: width] =
          w_rotl[(int'(ways) - 1 - p) * int'(width) +: width];
      end
      if (sw'(p) < w_sum) begin
        w_out[(int'(ways) - 1 - p) * int'(width) +: width] =
          w_merge[(int'(ways) - 1 - p) * int'(width) +: width];
      end
    end
  end

  // Next-state and next-output selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_hold_cnt_nxt = r_hold_cnt;
    w_o_v_nxt      = r_o_v & ~o_r;
    w_o_d_nxt      = r_o_d;
    w_o_cnt_nxt    = r_o_cnt;
    w_o_e_nxt      = r_o_e;
    case (r_state)
      S_RUN: begin
        if (w_acc) begin
          if (w_sum >= sw'(ways)) begin
            w_o_v_nxt      = 1'b1;
            w_o_d_nxt      = w_out;
            w_o_cnt_nxt    = cnt_width'(ways);
            w_o_e_nxt      = 1'b0;
            w_hold_nxt     = w_rotl;
            w_hold_cnt_nxt = cnt_width'(w_sum - sw'(ways));
            if (i_e) begin
              if (w_sum == sw'(ways)) begin
                w_o_e_nxt = 1'b1;
              end else begin
                w_state_nxt = S_FLUSH;
              end
            end
          end else if (i_e) begin
            w_o_v_nxt      = 1'b1;
            w_o_d_nxt      = w_out;
            w_o_cnt_nxt    = cnt_width'(w_sum);
            w_o_e_nxt      = 1'b1;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_nxt     = w_merge;
            w_hold_cnt_nxt = cnt_width'(w_sum);
          end
        end
      end
      S_FLUSH: begin
        if (w_ld) begin
          w_o_v_nxt      = 1'b1;
          w_o_d_nxt      = w_flush;
          w_o_cnt_nxt    = r_hold_cnt;
          w_o_e_nxt      = 1'b1;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_hold     <= '0;
      r_hold_cnt <= '0;
      r_o_v      <= 1'b0;
      r_o_d      <= '0;
      r_o_cnt    <= '0;
      r_o_e      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_o_v      <= w_o_v_nxt;
      r_o_d      <= w_o_d_nxt;
      r_o_cnt    <= w_o_cnt_nxt;
      r_o_e      <= w_o_e_nxt;
    end
  end

  assign i_r   = w_ir;
  assign o_v   = r_o_v;
  assign o_d   = r_o_d;
  assign o_cnt = r_o_cnt;
  assign o_e   = r_o_e;

  a_cnt_legal: assert property (@(posedge clk) disable iff (reset)
    (i_v && w_ir) |-> (i_cnt <= cnt_width'(ways)));

endmodule
